// File: rtl/bt_uart_rx_fifo_pkg.sv
// Shared definitions for the Bluetooth UART receive path: parity modes, receiver states, frame sizing.
package bt_uart_pkg;

    localparam int PAR_NONE = 0;
    localparam int PAR_EVEN = 1;
    localparam int PAR_ODD  = 2;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PAR,
        STOP
    } rx_state_t;

    // Start + data + optional parity + stop.
    function automatic int frame_bits(input int data_bits, input int parity);
        return 2 + data_bits + ((parity != PAR_NONE) ? 1 : 0);
    endfunction

endpackage

// File: rtl/bt_uart_rx_fifo_if.sv
// Receiver bus: serial line in, valid/ready character drain, occupancy and fault flags out.
interface bt_uart_rx_fifo_if #(
    parameter int DATA_BITS  = 8,
    parameter int FIFO_DEPTH = 16
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic                 Rx;
    logic [DATA_BITS-1:0] RxData;
    logic                 RxValid;
    logic                 RxReady;
    logic [CW-1:0]        FifoCount;
    logic                 FrameErr;
    logic                 ParityErr;
    logic                 Overflow;
    logic                 ErrClr;
    logic                 Timeout;

    modport master (
        input  Rx, RxReady, ErrClr,
        output RxData, RxValid, FifoCount, FrameErr, ParityErr, Overflow, Timeout
    );

    modport slave (
        output Rx, RxReady, ErrClr,
        input  RxData, RxValid, FifoCount, FrameErr, ParityErr, Overflow, Timeout
    );
endinterface

// File: rtl/bt_uart_rx_fifo_sync_fifo.sv
// Show-ahead synchronous FIFO: head visible on dat_o with zero read latency, write lands next cycle.
// Push on full is ignored unless a pop happens in the same cycle; pop on empty is ignored.
module bt_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         push_dat_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         dat_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic             do_push, do_pop;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign do_pop  = pop_i && !empty_o;
    // A full FIFO still accepts a write when the head leaves in the same cycle.
    assign do_push = push_i && (!full_o || do_pop);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            if (do_push && !do_pop)      count_q <= count_q + 1'b1;
            else if (do_pop && !do_push) count_q <= count_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= push_dat_i;
    end

    assign dat_o   = empty_o ? '0 : mem_q[rd_ptr_q];
    assign count_o = count_q;
endmodule

// File: rtl/bt_uart_rx_fifo.sv
// UART receiver with free-running baud ticks feeding a show-ahead FIFO; BT_RX_TIMEOUT_EN adds an idle flush pulse.
// Good character reaches RxValid two cycles after its stop sample; a full FIFO drops it and sets Overflow.
module bt_uart_rx_fifo
    import bt_uart_pkg::*;
#(
    parameter int BAUD_DIV      = 651,
    parameter int OVERSAMPLE    = 16,
    parameter int DATA_BITS     = 8,
    parameter int PARITY        = 0,
    parameter int FIFO_DEPTH    = 16,
    parameter int TIMEOUT_CHARS = 4
) (
    input  logic              Clk,
    input  logic              Rst,
    bt_uart_rx_fifo_if.master bus
);
    localparam logic [15:0] TICK_LAST = 16'(BAUD_DIV - 1);
    localparam logic [4:0]  OS_HALF   = 5'(OVERSAMPLE / 2 - 1);
    localparam logic [4:0]  OS_FULL   = 5'(OVERSAMPLE - 1);
    localparam logic [3:0]  BIT_LAST  = 4'(DATA_BITS - 1);
    localparam logic        PAR_INV   = (PARITY == PAR_ODD);
    localparam int          TO_LIMIT  = TIMEOUT_CHARS * frame_bits(DATA_BITS, PARITY) * OVERSAMPLE;

    logic                 sync1_q, sync2_q, rx_prev_q;
    logic [15:0]          tick_cnt_q;
    rx_state_t            state_q, state_d;
    logic [4:0]           os_cnt_q, os_cnt_d;
    logic [3:0]           bit_cnt_q, bit_cnt_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 bad_q, bad_d;
    logic                 push_vld_q, push_vld_d;
    logic                 frame_err_q, frame_err_d;
    logic                 parity_err_q, parity_err_d;
    logic                 overflow_q, overflow_d;
    logic                 tick, rx_fall, sample_now, pop, fifo_full, fifo_empty;

    assign tick       = (tick_cnt_q == TICK_LAST);
    assign rx_fall    = rx_prev_q & ~sync2_q;
    assign sample_now = tick && (os_cnt_q == ((state_q == START) ? OS_HALF : OS_FULL));
    assign pop        = bus.RxReady && !fifo_empty;

    always_comb begin
        state_d      = state_q;
        os_cnt_d     = os_cnt_q;
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        bad_d        = bad_q;
        push_vld_d   = 1'b0;
        frame_err_d  = frame_err_q & ~bus.ErrClr;
        parity_err_d = parity_err_q & ~bus.ErrClr;
        overflow_d   = overflow_q & ~bus.ErrClr;

        if (tick && state_q != IDLE) os_cnt_d = sample_now ? '0 : os_cnt_q + 5'd1;

        case (state_q)
            IDLE: if (rx_fall) begin
                state_d  = START;
                os_cnt_d = '0;
                bad_d    = 1'b0;
            end
            START: if (sample_now) begin
                state_d   = sync2_q ? IDLE : DATA;
                bit_cnt_d = '0;
            end
            DATA: if (sample_now) begin
                shift_d = {sync2_q, shift_q[DATA_BITS-1:1]};
                if (bit_cnt_q == BIT_LAST) state_d = (PARITY != PAR_NONE) ? PAR : STOP;
                else                       bit_cnt_d = bit_cnt_q + 4'd1;
            end
            PAR: if (sample_now) begin
                if (sync2_q != ((^shift_q) ^ PAR_INV)) begin
                    bad_d        = 1'b1;
                    parity_err_d = 1'b1;
                end
                state_d = STOP;
            end
            STOP: if (sample_now) begin
                if (!sync2_q)   frame_err_d = 1'b1;
                else if (!bad_q) push_vld_d = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (push_vld_q && fifo_full && !pop) overflow_d = 1'b1;
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            sync1_q      <= 1'b1;
            sync2_q      <= 1'b1;
            rx_prev_q    <= 1'b1;
            tick_cnt_q   <= '0;
            state_q      <= IDLE;
            os_cnt_q     <= '0;
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            bad_q        <= 1'b0;
            push_vld_q   <= 1'b0;
            frame_err_q  <= 1'b0;
            parity_err_q <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            sync1_q      <= bus.Rx;
            sync2_q      <= sync1_q;
            rx_prev_q    <= sync2_q;
            tick_cnt_q   <= tick ? '0 : tick_cnt_q + 16'd1;
            state_q      <= state_d;
            os_cnt_q     <= os_cnt_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            bad_q        <= bad_d;
            push_vld_q   <= push_vld_d;
            frame_err_q  <= frame_err_d;
            parity_err_q <= parity_err_d;
            overflow_q   <= overflow_d;
        end
    end

    // shift_q holds the finished character until the next frame reaches DATA.
    bt_sync_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i      (Clk),
        .rst_i      (Rst),
        .push_i     (push_vld_q),
        .push_dat_i (shift_q),
        .pop_i      (bus.RxReady),
        .dat_o      (bus.RxData),
        .full_o     (fifo_full),
        .empty_o    (fifo_empty),
        .count_o    (bus.FifoCount)
    );

    assign bus.RxValid   = !fifo_empty;
    assign bus.FrameErr  = frame_err_q;
    assign bus.ParityErr = parity_err_q;
    assign bus.Overflow  = overflow_q;

`ifdef BT_RX_TIMEOUT_EN
    logic [31:0] idle_cnt_q;
    logic        timeout_q;

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            idle_cnt_q <= '0;
            timeout_q  <= 1'b0;
        end else begin
            timeout_q <= 1'b0;
            if (push_vld_q || pop) begin
                idle_cnt_q <= '0;
            end else if (tick && idle_cnt_q < 32'(TO_LIMIT)) begin
                idle_cnt_q <= idle_cnt_q + 32'd1;
                timeout_q  <= !fifo_empty && (idle_cnt_q == 32'(TO_LIMIT - 1));
            end
        end
    end

    assign bus.Timeout = timeout_q;
`else
    // TO_LIMIT is always positive, so Timeout is held low.
    assign bus.Timeout = (TO_LIMIT < 0);
`endif
endmodule

// File: tb/tb_bt_uart_rx_fifo.sv
// Bench for bt_uart_rx_fifo: an 8N1 and an 8E1 instance driven with directed and random frames against a queue model.
`timescale 1ns/1ps
module tb_bt_uart_rx_fifo;
    localparam int BIT_CLKS = 4 * 16;
    localparam int DEPTH    = 16;

    logic Clk = 1'b0;
    logic Rst;
    always #5 Clk = ~Clk;

    bt_uart_rx_fifo_if #(.DATA_BITS(8), .FIFO_DEPTH(DEPTH)) if0 ();
    bt_uart_rx_fifo_if #(.DATA_BITS(8), .FIFO_DEPTH(DEPTH)) if1 ();

    bt_uart_rx_fifo #(.BAUD_DIV(4), .PARITY(0)) dut0 (.Clk(Clk), .Rst(Rst), .bus(if0));
    bt_uart_rx_fifo #(.BAUD_DIV(4), .PARITY(1)) dut1 (.Clk(Clk), .Rst(Rst), .bus(if1));

    int         n_cmp = 0;
    int         n_err = 0;
    logic [7:0] q0[$];
    logic [7:0] q1[$];
    bit         exp_fe[2];
    bit         exp_pe[2];
    bit         exp_ov[2];
    int         hi0 = 0;
    int         to_cnt0 = 0;
    int         to_cnt1 = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Consumer side: every accepted character must match the oldest expected one.
    always @(negedge Clk) begin
        if (!Rst) begin
            if (if0.RxValid) hi0++;
            if (if0.Timeout) to_cnt0++;
            if (if1.Timeout) to_cnt1++;
            if (if0.RxValid && if0.RxReady) begin
                if (q0.size() == 0) check_eq("pop0_extra", 32'(if0.RxValid), 0);
                else                check_eq("pop0_data", 32'(if0.RxData), 32'(q0.pop_front()));
            end
            if (if1.RxValid && if1.RxReady) begin
                if (q1.size() == 0) check_eq("pop1_extra", 32'(if1.RxValid), 0);
                else                check_eq("pop1_data", 32'(if1.RxData), 32'(q1.pop_front()));
            end
        end
    end

    function automatic int qsize(input int sel);
        return (sel == 0) ? q0.size() : q1.size();
    endfunction

    task automatic tx_bit(input int sel, input logic v);
        if (sel == 0) if0.Rx = v;
        else          if1.Rx = v;
        repeat (BIT_CLKS) @(posedge Clk);
    endtask

    task automatic send_char(input int sel, input logic [7:0] d, input logic stop_v, input logic bad_par);
        tx_bit(sel, 1'b0);
        for (int i = 0; i < 8; i++) tx_bit(sel, d[i]);
        if (sel == 1) tx_bit(sel, (^d) ^ bad_par);
        tx_bit(sel, stop_v);
    endtask

    task automatic send_good(input int sel, input logic [7:0] d);
        if (qsize(sel) >= DEPTH) exp_ov[sel] = 1'b1;
        else if (sel == 0)       q0.push_back(d);
        else                     q1.push_back(d);
        send_char(sel, d, 1'b1, 1'b0);
    endtask

    task automatic send_frame_err(input int sel, input logic [7:0] d);
        exp_fe[sel] = 1'b1;
        send_char(sel, d, 1'b0, 1'b0);
    endtask

    task automatic send_bad_par(input logic [7:0] d);
        exp_pe[1] = 1'b1;
        send_char(1, d, 1'b1, 1'b1);
    endtask

    task automatic set_rdy(input int sel, input logic v);
        @(posedge Clk); #1;
        if (sel == 0) if0.RxReady = v;
        else          if1.RxReady = v;
    endtask

    task automatic err_clr(input int sel);
        @(posedge Clk); #1;
        if (sel == 0) if0.ErrClr = 1'b1; else if1.ErrClr = 1'b1;
        @(posedge Clk); #1;
        if (sel == 0) if0.ErrClr = 1'b0; else if1.ErrClr = 1'b0;
        exp_fe[sel] = 1'b0;
        exp_pe[sel] = 1'b0;
        exp_ov[sel] = 1'b0;
    endtask

    task automatic check_flags(input int sel, input string tag);
        @(negedge Clk);
        if (sel == 0) begin
            check_eq({tag, "_fe0"}, 32'(if0.FrameErr),  32'(exp_fe[0]));
            check_eq({tag, "_pe0"}, 32'(if0.ParityErr), 32'(exp_pe[0]));
            check_eq({tag, "_ov0"}, 32'(if0.Overflow),  32'(exp_ov[0]));
        end else begin
            check_eq({tag, "_fe1"}, 32'(if1.FrameErr),  32'(exp_fe[1]));
            check_eq({tag, "_pe1"}, 32'(if1.ParityErr), 32'(exp_pe[1]));
            check_eq({tag, "_ov1"}, 32'(if1.Overflow),  32'(exp_ov[1]));
        end
    endtask

    task automatic check_rst(input string tag);
        @(negedge Clk);
        check_eq({tag, "_data"},  32'(if0.RxData),    0);
        check_eq({tag, "_valid"}, 32'(if0.RxValid),   0);
        check_eq({tag, "_count"}, 32'(if0.FifoCount), 0);
        check_eq({tag, "_flags"}, {29'd0, if0.FrameErr, if0.ParityErr, if0.Overflow}, 0);
        check_eq({tag, "_to"},    32'(if0.Timeout),   0);
        check_eq({tag, "_v1"},    32'(if1.RxValid),   0);
        check_eq({tag, "_c1"},    32'(if1.FifoCount), 0);
    endtask

    // Bounded wait for both FIFOs to empty with the consumer accepting.
    task automatic drain(input string tag);
        set_rdy(0, 1'b1);
        set_rdy(1, 1'b1);
        for (int i = 0; i < 400; i++) begin
            @(negedge Clk);
            if (!if0.RxValid && !if1.RxValid) break;
        end
        @(negedge Clk);
        check_eq({tag, "_left0"}, 32'(q0.size()), 0);
        check_eq({tag, "_left1"}, 32'(q1.size()), 0);
        check_eq({tag, "_cnt0"},  32'(if0.FifoCount), 0);
        check_eq({tag, "_cnt1"},  32'(if1.FifoCount), 0);
    endtask

    initial begin
        int         sel;
        int         kind;
        logic       rdy;
        logic [7:0] d;
        int         wait_clks;

        Rst = 1'b0;
        if0.Rx = 1'b1;      if1.Rx = 1'b1;
        if0.RxReady = 1'b0; if1.RxReady = 1'b0;
        if0.ErrClr = 1'b0;  if1.ErrClr = 1'b0;
        #2 Rst = 1'b1;
        repeat (4) @(posedge Clk);
        check_rst("rst");
        @(posedge Clk); #1 Rst = 1'b0;
        repeat (8) @(posedge Clk);

        // Plain 8N1 character with the consumer always ready.
        set_rdy(0, 1'b1);
        set_rdy(1, 1'b1);
        hi0 = 0;
        send_good(0, 8'hA5);
        tx_bit(0, 1'b1);
        @(negedge Clk);
        check_eq("a5_valid_cycles", 32'(hi0), 1);
        check_eq("a5_left", 32'(q0.size()), 0);
        check_eq("a5_count", 32'(if0.FifoCount), 0);
        check_flags(0, "a5");

        // Even parity: one good, one with the parity bit inverted.
        send_good(1, 8'h5A);
        tx_bit(1, 1'b1);
        check_eq("par_good_left", 32'(q1.size()), 0);
        send_bad_par(8'h03);
        tx_bit(1, 1'b1);
        check_flags(1, "par_bad");
        check_eq("par_bad_valid", 32'(if1.RxValid), 0);
        err_clr(1);
        check_flags(1, "par_clr");

        // Stop bit low, then the line stays low for three frame times.
        exp_fe[0] = 1'b1;
        tx_bit(0, 1'b0);
        for (int i = 0; i < 8; i++) tx_bit(0, i[0] ? 1'b0 : 1'b1);
        for (int i = 0; i < 31; i++) tx_bit(0, 1'b0);
        tx_bit(0, 1'b1);
        tx_bit(0, 1'b1);
        check_flags(0, "frame");
        check_eq("frame_count", 32'(if0.FifoCount), 0);
        err_clr(0);
        check_flags(0, "frame_clr");

        // Three-cycle low glitch on an idle line, then a normal character.
        @(posedge Clk); #1 if0.Rx = 1'b0;
        repeat (3) @(posedge Clk);
        #1 if0.Rx = 1'b1;
        tx_bit(0, 1'b1);
        tx_bit(0, 1'b1);
        check_flags(0, "glitch");
        check_eq("glitch_count", 32'(if0.FifoCount), 0);
        send_good(0, 8'h81);
        tx_bit(0, 1'b1);
        check_eq("glitch_after_left", 32'(q0.size()), 0);

        // Fill past capacity with the consumer stalled.
        set_rdy(0, 1'b0);
        for (int i = 0; i < 17; i++) send_good(0, 8'(i));
        tx_bit(0, 1'b1);
        @(negedge Clk);
        check_eq("ovf_count", 32'(if0.FifoCount), DEPTH);
        check_eq("ovf_head", 32'(if0.RxData), 0);
        check_flags(0, "ovf");
        drain("ovf_drain");
        err_clr(0);

        // Random mix of good, framing-error and parity-error characters.
        for (int n = 0; n < 20; n++) begin
            sel  = $urandom_range(0, 1);
            kind = $urandom_range(0, 7);
            d    = 8'($urandom);
            rdy  = 1'($urandom_range(0, 1));
            if (qsize(sel) >= 12) rdy = 1'b1;
            set_rdy(sel, rdy);
            if (kind == 0)                  send_frame_err(sel, d);
            else if (kind == 1 && sel == 1) send_bad_par(d);
            else                            send_good(sel, d);
            tx_bit(sel, 1'b1);
        end
        drain("rand_drain");
        check_flags(0, "rand");
        check_flags(1, "rand");

        // Reset in the middle of a data field with two characters buffered.
        set_rdy(0, 1'b0);
        send_good(0, 8'h11);
        send_good(0, 8'h22);
        tx_bit(0, 1'b1);
        @(negedge Clk);
        check_eq("mid_pre_count", 32'(if0.FifoCount), 2);
        tx_bit(0, 1'b0);
        tx_bit(0, 1'b1);
        tx_bit(0, 1'b0);
        tx_bit(0, 1'b1);
        @(posedge Clk); #1;
        Rst = 1'b1;
        if0.Rx = 1'b1;
        q0.delete();
        q1.delete();
        for (int s = 0; s < 2; s++) begin
            exp_fe[s] = 1'b0; exp_pe[s] = 1'b0; exp_ov[s] = 1'b0;
        end
        repeat (3) @(posedge Clk);
        check_rst("mid_rst");
        #1 Rst = 1'b0;
        set_rdy(0, 1'b1);
        send_good(0, 8'h3C);
        tx_bit(0, 1'b1);
        check_eq("post_rst_left", 32'(q0.size()), 0);
        check_flags(0, "post_rst");

`ifdef BT_RX_TIMEOUT_EN
        // One unread character: a single pulse after 4 x 10 x 16 ticks of idleness.
        set_rdy(0, 1'b0);
        to_cnt0 = 0;
        send_good(0, 8'h77);
        wait_clks = 0;
        for (int i = 0; i < 3200 && to_cnt0 == 0; i++) begin
            @(negedge Clk);
            wait_clks = i;
        end
        check_eq("to_window", 32'(wait_clks > 2300 && wait_clks < 2700), 1);
        repeat (3000) @(posedge Clk);
        check_eq("to_single", 32'(to_cnt0), 1);
        drain("to_drain");
`else
        wait_clks = 0;
        check_eq("timeout_never", 32'(to_cnt0 + to_cnt1 + wait_clks), 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
